// File: rtl/noc_pkg.sv
// Shared types for the local network interface: flit layout and TX FSM states.
// Destination field is {x[1:0], y[1:0]}.
package noc_pkg;
    localparam int DEST_W    = 4;
    localparam int PAYLOAD_W = 32;
    localparam int FLIT_W    = DEST_W + PAYLOAD_W;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} ni_tx_state_e;
endpackage

// File: rtl/noc_ni_fifo.sv
// Generic synchronous FIFO with occupancy count.
// Latency: push visible at dout/count the cycle after the write edge.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module noc_ni_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         din,
    input  logic                     pop,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/noc_local_ni.sv
// PE <-> router local-port interface: TX FIFO with credit-gated injection, RX FIFO with credit return.
// Latency: PE push in cycle N -> net_tx_valid_o in N+2; RX pop -> net_credit_o next cycle.
// Backpressure: pe_tx_ready_o drops when TX FIFO full; injection stalls at zero credit; RX overflow drops.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CREDITS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DEST_W-1:0] my_addr_i,
    input  logic [FLIT_W-1:0] pe_tx_flit_i,
    input  logic              pe_tx_valid_i,
    output logic              pe_tx_ready_o,
    output logic [FLIT_W-1:0] pe_rx_flit_o,
    output logic              pe_rx_valid_o,
    input  logic              pe_rx_ready_i,
    output logic [FLIT_W-1:0] net_tx_flit_o,
    output logic              net_tx_valid_o,
    input  logic              net_credit_i,
    input  logic [FLIT_W-1:0] net_rx_flit_i,
    input  logic              net_rx_valid_i,
    output logic              net_credit_o,
    output logic [15:0]       tx_count_o,
    output logic [15:0]       rx_count_o,
    output logic [2:0]        err_o
);
    localparam int CW  = $clog2(CREDITS + 1);
    localparam int TXW = $clog2(TX_DEPTH) + 1;
    localparam int RXW = $clog2(RX_DEPTH) + 1;

    ni_tx_state_e   state;
    logic [CW-1:0]  credit;
    logic [CW-1:0]  credit_nxt;
    logic [TXW-1:0] tx_cnt;
    logic [TXW-1:0] tx_cnt_nxt;
    logic [RXW-1:0] rx_cnt;
    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic           tx_push, inject, rx_pop, rx_push, credit_ovf;
    flit_t          tx_in, tx_head, rx_in, rx_head;

    assign tx_in         = pe_tx_flit_i;
    assign rx_in         = net_rx_flit_i;
    assign pe_tx_ready_o = !tx_full;
    assign tx_push       = pe_tx_valid_i && !tx_full;
    assign inject        = (state == SEND);
    assign rx_pop        = pe_rx_ready_i && !rx_empty;
    assign rx_push       = net_rx_valid_i && (!rx_full || rx_pop);
    assign pe_rx_valid_o = (rx_cnt != '0);
    assign pe_rx_flit_o  = rx_head;
    assign credit_ovf    = net_credit_i && !inject && (credit == CW'(CREDITS));
    assign tx_cnt_nxt    = tx_cnt + TXW'(tx_push) - TXW'(inject);

    always_comb begin
        credit_nxt = credit;
        if (inject && !net_credit_i)
            credit_nxt = credit - CW'(1);
        else if (net_credit_i && !inject && !credit_ovf)
            credit_nxt = credit + CW'(1);
    end

    noc_ni_fifo #(.DEPTH(TX_DEPTH), .T(flit_t)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .din(tx_in), .pop(inject),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
    );

    noc_ni_fifo #(.DEPTH(RX_DEPTH), .T(flit_t)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_in), .pop(rx_pop),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
    );

    // State is chosen from next-cycle occupancy and credit, so SEND always means "pop this cycle".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            credit         <= CW'(CREDITS);
            net_tx_flit_o  <= '0;
            net_tx_valid_o <= 1'b0;
            net_credit_o   <= 1'b0;
            tx_count_o     <= '0;
            rx_count_o     <= '0;
            err_o          <= '0;
        end else begin
            case (state)
                IDLE, SEND, WAIT: begin
                    if (tx_cnt_nxt == '0)      state <= IDLE;
                    else if (credit_nxt != '0) state <= SEND;
                    else                       state <= WAIT;
                end
                default: state <= IDLE;
            endcase
            credit         <= credit_nxt;
            net_tx_valid_o <= inject;
            net_credit_o   <= rx_pop;
            if (inject) begin
                net_tx_flit_o <= tx_head;
                tx_count_o    <= tx_count_o + 16'd1;
            end
            if (rx_push) rx_count_o <= rx_count_o + 16'd1;
            if (net_rx_valid_i && !rx_push)                 err_o[0] <= 1'b1;
            if (credit_ovf)                                 err_o[1] <= 1'b1;
            if (net_rx_valid_i && rx_in.dest != my_addr_i)  err_o[2] <= 1'b1;
        end
    end

    a_inject_needs_credit: assert property (@(posedge clk) disable iff (!rst)
        inject |-> (credit != '0) && !tx_empty);
endmodule
